// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory refill arbiter.
//   mem_arb_state_t     : sequencer states (IDLE / CMD / RDATA / WDATA)
//   mem_arb_owner_t     : which cache owns the current transaction
//   LINE_WORDS_DEFAULT  : default number of beats per cache line
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int LINE_WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// ---------------------------------------------------------------------------
// mem_arb_grant
// Combinational pick between the i-cache and d-cache request valids.
// When only one requester is valid it wins. When both are valid, the one
// that did NOT win last time wins; a caller that always presents
// last_owner = OWNER_IC therefore gets fixed d-cache priority.
// Ports:
//   ic_valid    in  i-cache request valid
//   dc_valid    in  d-cache request valid
//   last_owner  in  owner of the most recent grant
//   grant       out some requester is valid
//   owner       out the chosen requester (meaningful when grant is high)
// ---------------------------------------------------------------------------
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic           ic_valid,
  input  logic           dc_valid,
  input  mem_arb_owner_t last_owner,
  output logic           grant,
  output mem_arb_owner_t owner
);

  always_comb begin
    grant = ic_valid | dc_valid;
    owner = OWNER_IC;
    if (ic_valid && dc_valid) begin
      owner = (last_owner == OWNER_DC) ? OWNER_IC : OWNER_DC;
    end else if (dc_valid) begin
      owner = OWNER_DC;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// mem_refill_arbiter
// Shares the single off-chip memory port between i-cache refills, d-cache
// refills and d-cache line writebacks. One line transaction at a time: accept
// a request, issue one burst command, stream LINE_WORDS beats, then respond.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : contended grants alternate (one-bit last-grant register)
//   undefined : fixed priority, d-cache always beats i-cache
//
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   ic_req_valid/addr/ready          i-cache refill request
//   dc_req_valid/write/addr/ready    d-cache refill or writeback request
//   dc_wdata, dc_wdata_pop           writeback word stream from the d-cache
//   mem_cmd_valid/write/addr/ready   burst command to memory
//   mem_rdata_valid, mem_rdata       read beats from memory
//   mem_wdata_valid/wdata/ready      write beats to memory
//   ic_rsp_valid, dc_rsp_valid       response strobes to the owning cache
//   rsp_data, rsp_last               response data / final beat or write ack
//   busy                             a transaction is in progress
// ---------------------------------------------------------------------------
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  input  logic              dc_req_valid,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_pop,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_cmd_ready,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wdata_valid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wdata_ready,
  output logic              ic_rsp_valid,
  output logic              dc_rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  mem_arb_state_t    state_reg;
  mem_arb_owner_t    owner_reg;
  logic              write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  // Set once the final write beat has been taken; the following WDATA cycle
  // is spent on the write acknowledgement instead of another beat.
  logic              ack_reg;

  logic              grant;
  mem_arb_owner_t    grant_owner;
  mem_arb_owner_t    last_owner;
  logic              accept;
  logic              rd_beat;
  logic              last_cnt;
  logic              wr_ack;
  logic [ADDR_W-1:0] req_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  mem_arb_owner_t last_reg;

  // Reset to "i-cache won last" so the d-cache wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= OWNER_IC;
    end else if (accept) begin
      last_reg <= grant_owner;
    end
  end

  assign last_owner = last_reg;
`else
  // Presenting a constant "i-cache won last" makes the picker favour the
  // d-cache on every contended cycle.
  assign last_owner = OWNER_IC;
`endif

  mem_arb_grant u_grant (
    .ic_valid   (ic_req_valid),
    .dc_valid   (dc_req_valid),
    .last_owner (last_owner),
    .grant      (grant),
    .owner      (grant_owner)
  );

  // rst_n is folded in so the request readies stay low while reset is held.
  assign accept       = (state_reg == IDLE) && grant && rst_n;
  assign ic_req_ready = accept && (grant_owner == OWNER_IC);
  assign dc_req_ready = accept && (grant_owner == OWNER_DC);
  assign req_addr     = (grant_owner == OWNER_DC) ? dc_req_addr : ic_req_addr;

  assign mem_cmd_valid = (state_reg == CMD);
  assign mem_cmd_write = (state_reg == CMD) && write_reg;
  assign mem_cmd_addr  = (state_reg == CMD) ? addr_reg : '0;

  assign last_cnt = (cnt_reg == CNT_W'(LINE_WORDS - 1));
  assign rd_beat  = (state_reg == RDATA) && mem_rdata_valid;
  assign wr_ack   = (state_reg == WDATA) && ack_reg;

  assign mem_wdata_valid = (state_reg == WDATA) && !ack_reg;
  assign mem_wdata       = mem_wdata_valid ? dc_wdata : '0;
  assign dc_wdata_pop    = mem_wdata_valid && mem_wdata_ready;

  assign ic_rsp_valid = rd_beat && (owner_reg == OWNER_IC);
  assign dc_rsp_valid = (rd_beat && (owner_reg == OWNER_DC)) || wr_ack;
  assign rsp_data     = rd_beat ? mem_rdata : '0;
  assign rsp_last     = (rd_beat && last_cnt) || wr_ack;
  assign busy         = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= OWNER_IC;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg <= grant_owner;
            write_reg <= (grant_owner == OWNER_DC) && dc_req_write;
            addr_reg  <= {req_addr[ADDR_W-1:CNT_W], CNT_W'(0)};
            cnt_reg   <= '0;
            ack_reg   <= 1'b0;
            state_reg <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            state_reg <= write_reg ? WDATA : RDATA;
          end
        end
        RDATA: begin
          if (mem_rdata_valid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_cnt) begin
              state_reg <= IDLE;
            end
          end
        end
        WDATA: begin
          if (ack_reg) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end else if (mem_wdata_ready) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (last_cnt) begin
              ack_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_refill_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model predicts every DUT output each cycle; logs of what the DUT
// actually did are also compared against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mem_refill_arbiter;

  localparam int LW = 4;
  localparam int AW = 26;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req_valid = 1'b0;
  logic [AW-1:0] ic_req_addr = '0;
  logic          ic_req_ready;
  logic          dc_req_valid = 1'b0;
  logic          dc_req_write = 1'b0;
  logic [AW-1:0] dc_req_addr = '0;
  logic          dc_req_ready;
  logic [DW-1:0] dc_wdata;
  logic          dc_wdata_pop;
  logic          mem_cmd_valid;
  logic          mem_cmd_write;
  logic [AW-1:0] mem_cmd_addr;
  logic          mem_cmd_ready = 1'b0;
  logic          mem_rdata_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_wdata_valid;
  logic [DW-1:0] mem_wdata;
  logic          mem_wdata_ready = 1'b0;
  logic          ic_rsp_valid;
  logic          dc_rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;

  always #5 clk = ~clk;

  mem_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
    .dc_req_ready(dc_req_ready), .dc_wdata(dc_wdata), .dc_wdata_pop(dc_wdata_pop),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_ready(mem_cmd_ready), .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
    .ic_rsp_valid(ic_rsp_valid), .dc_rsp_valid(dc_rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy)
  );

  // d-cache writeback source: word value advances on each pop
  logic [DW-1:0] wb_idx = '0;
  always @(posedge clk) if (dc_wdata_pop) wb_idx <= wb_idx + 1'b1;
  assign dc_wdata = 32'h0000_5000 + wb_idx;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Logs of observed DUT behaviour for literal checks
  int            grant_q[$];   // 1 = d-cache, 0 = i-cache
  logic [AW-1:0] caddr_q[$];
  bit            cwrite_q[$];
  logic [DW-1:0] rsp_d_q[$];
  bit            rsp_o_q[$];   // 1 = d-cache strobe
  bit            rsp_l_q[$];
  logic [DW-1:0] wd_q[$];
  int            pop_cnt = 0;
  int            cmd_cycles = 0;

  // Reference model: one outstanding transaction described by its phase.
  bit            m_active = 0;
  bit            m_cmd = 0;
  bit            m_write = 0;
  bit            m_dc = 0;
  bit            m_last_dc = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_beats = 0;

  initial begin
    logic          e_icr, e_dcr, e_cv, e_cw, e_wv, e_pop, e_icv, e_dcv, e_last, e_busy;
    logic [AW-1:0] e_caddr, a;
    logic [DW-1:0] e_wd, e_rd;
    bit            win_dc;
    forever begin
      @(negedge clk);
      e_icr = 0; e_dcr = 0; e_cv = 0; e_cw = 0; e_wv = 0; e_pop = 0;
      e_icv = 0; e_dcv = 0; e_last = 0; e_busy = 0;
      e_caddr = '0; e_wd = '0; e_rd = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_dc = (ic_req_valid && dc_req_valid) ? !m_last_dc : dc_req_valid;
`else
      win_dc = dc_req_valid;
`endif
      if (rst_n) begin
        e_busy = m_active;
        if (!m_active) begin
          if (ic_req_valid || dc_req_valid) begin
            e_dcr = win_dc;
            e_icr = !win_dc;
          end
        end else if (m_cmd) begin
          e_cv = 1; e_cw = m_write; e_caddr = m_addr;
        end else if (!m_write) begin
          if (mem_rdata_valid) begin
            e_rd = mem_rdata;
            if (m_dc) e_dcv = 1; else e_icv = 1;
            e_last = (m_beats == LW - 1);
          end
        end else if (m_beats < LW) begin
          e_wv = 1; e_wd = dc_wdata; e_pop = mem_wdata_ready;
        end else begin
          e_dcv = 1; e_last = 1;
        end
      end
      chk("ic_req_ready", 64'(ic_req_ready), 64'(e_icr));
      chk("dc_req_ready", 64'(dc_req_ready), 64'(e_dcr));
      chk("mem_cmd_valid", 64'(mem_cmd_valid), 64'(e_cv));
      chk("mem_cmd_write", 64'(mem_cmd_write), 64'(e_cw));
      chk("mem_cmd_addr", 64'(mem_cmd_addr), 64'(e_caddr));
      chk("mem_wdata_valid", 64'(mem_wdata_valid), 64'(e_wv));
      chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
      chk("dc_wdata_pop", 64'(dc_wdata_pop), 64'(e_pop));
      chk("ic_rsp_valid", 64'(ic_rsp_valid), 64'(e_icv));
      chk("dc_rsp_valid", 64'(dc_rsp_valid), 64'(e_dcv));
      chk("rsp_data", 64'(rsp_data), 64'(e_rd));
      chk("rsp_last", 64'(rsp_last), 64'(e_last));
      chk("busy", 64'(busy), 64'(e_busy));

      // observation logs (from the DUT)
      if (dc_req_ready) grant_q.push_back(1);
      if (ic_req_ready) grant_q.push_back(0);
      if (mem_cmd_valid) cmd_cycles++;
      if (mem_cmd_valid && mem_cmd_ready) begin
        caddr_q.push_back(mem_cmd_addr);
        cwrite_q.push_back(mem_cmd_write);
      end
      if (ic_rsp_valid || dc_rsp_valid) begin
        rsp_d_q.push_back(rsp_data);
        rsp_o_q.push_back(dc_rsp_valid);
        rsp_l_q.push_back(rsp_last);
      end
      if (mem_wdata_valid && mem_wdata_ready) wd_q.push_back(mem_wdata);
      if (dc_wdata_pop) pop_cnt++;

      // model advance
      if (!rst_n) begin
        m_active = 0; m_last_dc = 0;
      end else if (!m_active) begin
        if (ic_req_valid || dc_req_valid) begin
          m_active = 1; m_cmd = 1; m_dc = win_dc; m_last_dc = win_dc;
          m_write = win_dc && dc_req_write;
          a = win_dc ? dc_req_addr : ic_req_addr;
          m_addr = a & ~AW'(LW - 1);
          m_beats = 0;
        end
      end else if (m_cmd) begin
        if (mem_cmd_ready) m_cmd = 0;
      end else if (!m_write) begin
        if (mem_rdata_valid) begin
          m_beats++;
          if (m_beats == LW) m_active = 0;
        end
      end else if (m_beats < LW) begin
        if (mem_wdata_ready) m_beats++;
      end else begin
        m_active = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ic_req_valid = 0; dc_req_valid = 0; dc_req_write = 0;
    mem_cmd_ready = 0; mem_rdata_valid = 0; mem_wdata_ready = 0;
  endtask

  task automatic clear_logs();
    grant_q.delete(); caddr_q.delete(); cwrite_q.delete();
    rsp_d_q.delete(); rsp_o_q.delete(); rsp_l_q.delete(); wd_q.delete();
    pop_cnt = 0; cmd_cycles = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  initial begin
    logic [DW-1:0] base;
    int n;

    // reset state
    step(); step();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_cmd_valid", 64'(mem_cmd_valid), 64'(0));
    rst_n = 1;
    step();

    // read refill, i-cache, addr 0x123
    clear_logs();
    ic_req_valid = 1; ic_req_addr = 26'h123; mem_cmd_ready = 1;
    step();
    ic_req_valid = 0;
    step();
    mem_cmd_ready = 0;
    for (int i = 0; i < LW; i++) begin
      mem_rdata_valid = 1; mem_rdata = 32'hA0 + 32'(i);
      step();
    end
    mem_rdata_valid = 0;
    step();
    chk("rd_grant_n", 64'(grant_q.size()), 64'(1));
    chk("rd_cmd_addr", 64'(caddr_q.size() > 0 ? caddr_q[0] : '1), 64'(26'h120));
    chk("rd_beats_n", 64'(rsp_d_q.size()), 64'(4));
    for (int i = 0; i < rsp_d_q.size() && i < 4; i++) begin
      chk("rd_beat_data", 64'(rsp_d_q[i]), 64'(32'hA0 + 32'(i)));
      chk("rd_beat_owner", 64'(rsp_o_q[i]), 64'(0));
      chk("rd_beat_last", 64'(rsp_l_q[i]), 64'(i == 3));
    end

    // writeback, d-cache, addr 0x200, wready toggling
    clear_logs();
    base = wb_idx;
    dc_req_valid = 1; dc_req_write = 1; dc_req_addr = 26'h200;
    step();
    dc_req_valid = 0; dc_req_write = 0; mem_cmd_ready = 1;
    for (int i = 0; i < 16; i++) begin
      mem_wdata_ready = i[0];
      step();
    end
    quiet();
    step();
    chk("wb_pops", 64'(pop_cnt), 64'(4));
    chk("wb_words_n", 64'(wd_q.size()), 64'(4));
    for (int i = 0; i < wd_q.size() && i < 4; i++)
      chk("wb_word", 64'(wd_q[i]), 64'(32'h5000 + base + 32'(i)));
    chk("wb_cmd_write", 64'(cwrite_q.size() > 0 ? cwrite_q[0] : 1'b0), 64'(1));
    chk("wb_cmd_addr", 64'(caddr_q.size() > 0 ? caddr_q[0] : '1), 64'(26'h200));
    chk("wb_ack_n", 64'(rsp_d_q.size()), 64'(1));
    if (rsp_d_q.size() > 0) begin
      chk("wb_ack_data", 64'(rsp_d_q[0]), 64'(0));
      chk("wb_ack_owner", 64'(rsp_o_q[0]), 64'(1));
      chk("wb_ack_last", 64'(rsp_l_q[0]), 64'(1));
    end

    // contention: both held valid for 4 transactions
    do_reset();
    clear_logs();
    ic_req_valid = 1; ic_req_addr = 26'h1000;
    dc_req_valid = 1; dc_req_addr = 26'h2004;
    mem_cmd_ready = 1; mem_rdata_valid = 1; mem_rdata = 32'hCAFE;
    n = 0;
    while (grant_q.size() < 4 && n < 60) begin
      step();
      n++;
    end
    ic_req_valid = 0; dc_req_valid = 0;
    for (int i = 0; i < 8; i++) step();
    quiet();
    chk("cont_grants_n", 64'(grant_q.size()), 64'(4));
    for (int i = 0; i < grant_q.size() && i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("cont_grant", 64'(grant_q[i]), 64'(i % 2 == 0 ? 1 : 0));
`else
      chk("cont_grant", 64'(grant_q[i]), 64'(1));
`endif
    end

    // command backpressure with early read data
    do_reset();
    clear_logs();
    ic_req_valid = 1; ic_req_addr = 26'h3F7;
    step();
    ic_req_valid = 0; mem_rdata_valid = 1; mem_rdata = 32'hBAD;
    for (int i = 0; i < 5; i++) step();
    mem_cmd_ready = 1;
    step();
    mem_cmd_ready = 0;
    for (int i = 0; i < LW; i++) begin
      mem_rdata = 32'hB0 + 32'(i);
      step();
    end
    quiet();
    step();
    chk("bp_cmd_cycles", 64'(cmd_cycles), 64'(6));
    chk("bp_cmd_addr", 64'(caddr_q.size() > 0 ? caddr_q[0] : '1), 64'(26'h3F4));
    chk("bp_beats_n", 64'(rsp_d_q.size()), 64'(4));
    if (rsp_d_q.size() > 0) chk("bp_first_beat", 64'(rsp_d_q[0]), 64'(32'hB0));

    // reset mid-burst after two beats
    ic_req_valid = 1; ic_req_addr = 26'h40; mem_cmd_ready = 1;
    step();
    ic_req_valid = 0;
    step();
    mem_rdata_valid = 1; mem_rdata = 32'h11;
    step(); step();
    rst_n = 0;
    #1;
    chk("rst_busy_immediate", 64'(busy), 64'(0));
    quiet();
    step(); step();
    rst_n = 1;
    step();
    clear_logs();
    dc_req_valid = 1; dc_req_write = 0; dc_req_addr = 26'h8B; mem_cmd_ready = 1;
    step();
    dc_req_valid = 0;
    step();
    mem_cmd_ready = 0;
    for (int i = 0; i < LW; i++) begin
      mem_rdata_valid = 1; mem_rdata = 32'hD0 + 32'(i);
      step();
    end
    quiet();
    step();
    chk("rst_cmd_addr", 64'(caddr_q.size() > 0 ? caddr_q[0] : '1), 64'(26'h88));
    chk("rst_beats_n", 64'(rsp_d_q.size()), 64'(4));
    for (int i = 0; i < rsp_d_q.size() && i < 4; i++) begin
      chk("rst_beat_owner", 64'(rsp_o_q[i]), 64'(1));
      chk("rst_beat_last", 64'(rsp_l_q[i]), 64'(i == 3));
    end

    // stray read data in IDLE and CMD
    clear_logs();
    mem_rdata_valid = 1; mem_rdata = 32'hEE;
    step(); step(); step();
    ic_req_valid = 1; ic_req_addr = 26'h77;
    step();
    ic_req_valid = 0;
    step(); step(); step();
    chk("stray_no_rsp", 64'(rsp_d_q.size()), 64'(0));
    quiet();
    mem_cmd_ready = 1;
    step();
    mem_cmd_ready = 0; mem_rdata_valid = 1;
    for (int i = 0; i < LW; i++) step();
    quiet();
    step();
    chk("stray_after_beats", 64'(rsp_d_q.size()), 64'(4));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ic_req_valid    = ($urandom_range(0, 2) == 0);
      ic_req_addr     = AW'($urandom);
      dc_req_valid    = ($urandom_range(0, 2) == 0);
      dc_req_write    = $urandom_range(0, 1) == 1;
      dc_req_addr     = AW'($urandom);
      mem_cmd_ready   = $urandom_range(0, 1) == 1;
      mem_rdata_valid = ($urandom_range(0, 4) < 3);
      mem_rdata       = $urandom;
      mem_wdata_ready = $urandom_range(0, 1) == 1;
      rst_n           = !(i >= 1500 && i < 1502);
      step();
    end
    quiet();
    rst_n = 1;
    for (int i = 0; i < 20; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_refill_arbiter.md
# mem_refill_arbiter

Sequences the single off-chip memory port between instruction-cache refills, data-cache refills and data-cache line writebacks. It accepts one line request at a time, issues a single burst command, and streams `LINE_WORDS` beats. Read beats are returned to the owning cache; write beats are taken from the d-cache. It sits between the cache miss handlers (i-cache, d-cache) and the memory interface, and its acknowledgements end the `dc_miss` stall that freezes the execute/memory pipeline register.

## Interface
Parameters:
- `LINE_WORDS`, 4: beats per line; power of two, at least 2.
- `ADDR_W`, 26: word-address width.
- `DATA_W`, 32: beat width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ic_req_valid`  in  1  i-cache refill request.
- `ic_req_addr`  in  ADDR_W  i-cache miss word address.
- `ic_req_ready`  out  1  i-cache request accepted this cycle.
- `dc_req_valid`  in  1  d-cache request.
- `dc_req_write`  in  1  1 = writeback, 0 = refill.
- `dc_req_addr`  in  ADDR_W  d-cache word address.
- `dc_req_ready`  out  1  d-cache request accepted this cycle.
- `dc_wdata`  in  DATA_W  current writeback word.
- `dc_wdata_pop`  out  1  `dc_wdata` consumed; the d-cache advances to the next word.
- `mem_cmd_valid`  out  1  burst command valid.
- `mem_cmd_write`  out  1  burst direction.
- `mem_cmd_addr`  out  ADDR_W  line-aligned burst address.
- `mem_cmd_ready`  in  1  command taken.
- `mem_rdata_valid`  in  1  read beat valid.
- `mem_rdata`  in  DATA_W  read beat data.
- `mem_wdata_valid`  out  1  write beat valid.
- `mem_wdata`  out  DATA_W  write beat data.
- `mem_wdata_ready`  in  1  write beat taken.
- `ic_rsp_valid`  out  1  beat for the i-cache.
- `dc_rsp_valid`  out  1  beat or write acknowledgement for the d-cache.
- `rsp_data`  out  DATA_W  response data.
- `rsp_last`  out  1  final beat or write acknowledgement.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CMD, RDATA, WDATA.
- **IDLE:** if any request is valid, grant one (see Configuration), then:
  - pulse that requester's `*_req_ready`;
  - latch owner, direction, and address with the low log2(`LINE_WORDS`) bits forced to 0;
  - clear the beat counter;
  - go to CMD.
- **CMD:** hold `mem_cmd_*` stable until `mem_cmd_ready`, then go to RDATA or WDATA.
- **RDATA:** each `mem_rdata_valid` is forwarded combinationally:
  - `rsp_data = mem_rdata`, with the owner's `*_rsp_valid` asserted;
  - the counter increments;
  - on beat `LINE_WORDS-1`, assert `rsp_last` and go to IDLE.
- **WDATA:**
  - `mem_wdata_valid = 1`, `mem_wdata = dc_wdata`, `dc_wdata_pop = mem_wdata_ready`.
  - After the final accepted beat, pulse `dc_rsp_valid` and `rsp_last` on the next cycle with `rsp_data = 0`, then go to IDLE.
- The beat counter is log2(`LINE_WORDS`) bits and wraps to 0 naturally on the last beat.
- `mem_rdata_valid` outside RDATA is ignored. A request deasserted before acceptance is dropped without effect.
- Reset (any time, including mid-burst):
  - state returns to IDLE;
  - every output is 0, except `mem_cmd_addr`, `mem_wdata` and `rsp_data`, which are also 0;
  - the round-robin pointer is set so the d-cache wins first;
  - any in-flight transaction is abandoned with no response.

## Timing
- Acceptance is combinational in IDLE: `*_req_ready` is high in the same cycle T as `*_req_valid`.
- `mem_cmd_valid` first rises at T+1.
- Read: if `mem_cmd_ready` is high at T+1, the earliest beat is at T+2, with zero added latency per beat.
- The earliest next acceptance is the cycle after `rsp_last`.
- Write: with `mem_wdata_ready` held high, beats are on T+2..T+1+`LINE_WORDS` and the acknowledgement on T+2+`LINE_WORDS`.
- At most one outstanding transaction. No request is accepted while `busy` is high.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - when both requesters are valid in the same IDLE cycle, the grant alternates;
  - a one-bit last-grant register is updated on every grant.
- Undefined: fixed priority, with the d-cache always winning over the i-cache. No pointer register exists.

## Structure
- `mem_arb_pkg`:
  - `mem_arb_state_t` (IDLE/CMD/RDATA/WDATA);
  - `mem_arb_owner_t` (OWNER_IC/OWNER_DC);
  - the default `LINE_WORDS` constant.
- One sub-module, `mem_arb_grant`: a combinational pick from the two valids and the last-grant bit, producing a grant and an owner.

## Test plan
- **Read refill:** i-cache request only, addr 0x123 -> `mem_cmd_addr` 0x120 at T+1; 4 beats 0xA0..0xA3 appear on `rsp_data` with `ic_rsp_valid`; `rsp_last` on 0xA3.
- **Writeback:** d-cache write at 0x200 with `mem_wdata_ready` toggling every other cycle -> exactly 4 `dc_wdata_pop` pulses, words in order, then a single `dc_rsp_valid`+`rsp_last`.
- **Contention:** both requesters held valid for 4 transactions:
  - with `MEM_ARB_ROUND_ROBIN_EN`, grants go DC, IC, DC, IC;
  - without it, DC four times.
- **Backpressure:** `mem_cmd_ready` low for 5 cycles -> command fields stable throughout; no beat is accepted early.
- **Reset mid-burst:** `rst_n` low after 2 read beats -> `busy` is 0 immediately; the next request restarts cleanly with a full 4-beat burst.
- **Stray data:** `mem_rdata_valid` pulsed in IDLE and CMD -> no `*_rsp_valid` asserted.
